// File: rtl/bgm_pkg.sv
// Shared types and helpers for the background-music sequencer.
// Holds the state encoding and the beat-divider sizing helpers.
package bgm_pkg;

  typedef enum logic [1:0] {
    FIELD        = 2'd0,
    GAP_TO_BOSS  = 2'd1,
    BOSS         = 2'd2,
    GAP_TO_FIELD = 2'd3
  } bgm_state_e;

  localparam int unsigned GAP_W = 8;

  // Clock cycles per beat.
  function automatic int unsigned beat_div(
    input int unsigned clk_hz,
    input int unsigned beat_hz
  );
    return clk_hz / beat_hz;
  endfunction

  // Width of the beat divider counter.
  function automatic int unsigned beat_div_w(
    input int unsigned clk_hz,
    input int unsigned beat_hz
  );
    return $clog2(beat_div(clk_hz, beat_hz));
  endfunction

endpackage

// File: rtl/bgm_sequencer_beat_divider.sv
// Beat divider: counts clock cycles and pulses tick once per beat.
// Holds while en is low; clr restarts the beat from count 0.
module beat_divider #(
  parameter int unsigned DIV = 10,
  parameter int unsigned W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: maps boss events to track select,
// mute and a restart pulse, inserting a silent gap per switch.
module bgm_sequencer
  import bgm_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BEAT_HZ   = 32,
  parameter int unsigned GAP_BEATS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic boss_enter,
  input  logic boss_clear,
  input  logic pause,
  output logic change,
  output logic mute,
  output logic music_rst,
  output logic boss_active
);

  localparam int unsigned DIV   = beat_div(CLK_HZ, BEAT_HZ);
  localparam int unsigned DIV_W = beat_div_w(CLK_HZ, BEAT_HZ);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_BEATS);

  bgm_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             change_q, change_d;
  logic             mute_q, mute_d;
  logic             mrst_q, mrst_d;
  logic             bact_q, bact_d;
  logic             div_clr;
  logic             tick;

  beat_divider #(
    .DIV (DIV),
    .W   (DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (!pause),
    .tick (tick)
  );

  // Next state, gap countdown and registered output values.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    change_d = change_q;
    mrst_d   = 1'b0;
    div_clr  = 1'b0;
    unique case (state_q)
      FIELD: begin
        if (boss_enter && !boss_clear) begin
          state_d = GAP_TO_BOSS;
          gap_d   = GAP_LOAD;
          div_clr = 1'b1;
        end
      end
      GAP_TO_BOSS: begin
        if (boss_clear) begin
          state_d = GAP_TO_FIELD;
          gap_d   = GAP_LOAD;
          div_clr = 1'b1;
        end else if (tick) begin
          if (gap_q <= 8'd1) begin
            state_d  = BOSS;
            gap_d    = '0;
            mrst_d   = 1'b1;
            change_d = 1'b1;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end
      BOSS: begin
        if (boss_clear) begin
          state_d = GAP_TO_FIELD;
          gap_d   = GAP_LOAD;
          div_clr = 1'b1;
        end
      end
      GAP_TO_FIELD: begin
        if (boss_enter && !boss_clear) begin
          state_d = GAP_TO_BOSS;
          gap_d   = GAP_LOAD;
          div_clr = 1'b1;
        end else if (tick) begin
          if (gap_q <= 8'd1) begin
            state_d  = FIELD;
            gap_d    = '0;
            mrst_d   = 1'b1;
            change_d = 1'b0;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end
    endcase
    mute_d = pause
          || (state_d == GAP_TO_BOSS)
          || (state_d == GAP_TO_FIELD);
    bact_d = (state_d == GAP_TO_BOSS)
          || (state_d == BOSS);
  end

  // State, gap counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FIELD;
      gap_q    <= '0;
      change_q <= 1'b0;
      mute_q   <= 1'b0;
      mrst_q   <= 1'b0;
      bact_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      change_q <= change_d;
      mute_q   <= mute_d;
      mrst_q   <= mrst_d;
      bact_q   <= bact_d;
    end
  end

  assign change      = change_q;
  assign mute        = mute_q;
  assign music_rst   = mrst_q;
  assign boss_active = bact_q;

endmodule

// File: tb/tb_bgm_sequencer.sv
// Testbench for bgm_sequencer with DIV=10 and a 4-beat gap.
// Segment table with end-of-segment constants plus a cycle model.
module tb_bgm_sequencer;

  localparam int FULL = 40;

  logic clk = 1'b0;
  logic rst;
  logic be, bc, pz;
  logic change, mute, music_rst, boss_active;

  always #5 clk = ~clk;

  bgm_sequencer #(
    .CLK_HZ    (320),
    .BEAT_HZ   (32),
    .GAP_BEATS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boss_enter  (be),
    .boss_clear  (bc),
    .pause       (pz),
    .change      (change),
    .mute        (mute),
    .music_rst   (music_rst),
    .boss_active (boss_active)
  );

  typedef struct packed {
    logic ch;
    logic mu;
    logic mr;
    logic ba;
  } exp_t;

  typedef struct {
    bit e;
    bit c;
    bit p;
    int n;
    bit ch;
    bit mu;
    bit mr;
    bit ba;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_st;
  int   m_rem;
  logic m_ch, m_mu, m_mr, m_ba;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_rem = 0;
    m_ch = 0; m_mu = 0; m_mr = 0; m_ba = 0;
  endtask

  // Gap tracked as remaining unpaused cycles.
  task automatic model_step(input bit e, input bit c, input bit p);
    m_mr = 0;
    case (m_st)
      0: if (e && !c) begin m_st = 1; m_rem = FULL; end
      1: begin
        if (c) begin m_st = 3; m_rem = FULL; end
        else if (!p) begin
          m_rem--;
          if (m_rem == 0) begin m_st = 2; m_mr = 1; m_ch = 1; end
        end
      end
      2: if (c) begin m_st = 3; m_rem = FULL; end
      default: begin
        if (e && !c) begin m_st = 1; m_rem = FULL; end
        else if (!p) begin
          m_rem--;
          if (m_rem == 0) begin m_st = 0; m_mr = 1; m_ch = 0; end
        end
      end
    endcase
    m_mu = p || (m_st == 1) || (m_st == 3);
    m_ba = (m_st == 1) || (m_st == 2);
  endtask

  task automatic step(input bit e, input bit c, input bit p);
    exp_t x;
    be = e; bc = c; pz = p;
    model_step(e, c, p);
    q.push_back('{m_ch, m_mu, m_mr, m_ba});
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("sb_change", change, x.ch);
    chk("sb_mute", mute, x.mu);
    chk("sb_music_rst", music_rst, x.mr);
    chk("sb_boss_active", boss_active, x.ba);
    be = 0; bc = 0; pz = 0;
  endtask

  task automatic run_gap(input string name, input int want);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0);
      n++;
      if (music_rst === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no music_rst within 200 cycles", name);
    end else begin
      chk_int(name, n, want);
    end
  endtask

  initial begin
    rst = 1; be = 0; bc = 0; pz = 0;
    //            e c p   n  ch mu mr ba
    vecs.push_back('{0,0,0,100, 0,0,0,0});
    vecs.push_back('{1,0,0,  1, 0,1,0,1});
    vecs.push_back('{0,0,0, 39, 0,1,0,1});
    vecs.push_back('{0,0,0,  1, 1,0,1,1});
    vecs.push_back('{0,0,0,  5, 1,0,0,1});
    vecs.push_back('{1,0,0,  1, 1,0,0,1});
    vecs.push_back('{0,1,0,  1, 1,1,0,0});
    vecs.push_back('{0,0,0, 10, 1,1,0,0});
    vecs.push_back('{0,0,0, 29, 1,1,0,0});
    vecs.push_back('{0,0,0,  1, 0,0,1,0});
    vecs.push_back('{1,0,0,  1, 0,1,0,1});
    vecs.push_back('{0,0,0, 14, 0,1,0,1});
    vecs.push_back('{0,1,0,  1, 0,1,0,0});
    vecs.push_back('{0,0,0, 39, 0,1,0,0});
    vecs.push_back('{0,0,0,  1, 0,0,1,0});
    vecs.push_back('{1,0,0,  1, 0,1,0,1});
    vecs.push_back('{0,0,0,  9, 0,1,0,1});
    vecs.push_back('{0,0,1, 25, 0,1,0,1});
    vecs.push_back('{0,0,0, 30, 0,1,0,1});
    vecs.push_back('{0,0,0,  1, 1,0,1,1});
    vecs.push_back('{0,1,0,  1, 1,1,0,0});
    vecs.push_back('{0,0,0, 40, 0,0,1,0});
    vecs.push_back('{1,1,0,  1, 0,0,0,0});
    vecs.push_back('{0,0,0,  5, 0,0,0,0});
    vecs.push_back('{0,0,1,  3, 0,1,0,0});
    vecs.push_back('{0,0,0,  1, 0,0,0,0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_change", change, 1'b0);
    chk("rst_mute", mute, 1'b0);
    chk("rst_music_rst", music_rst, 1'b0);
    chk("rst_boss_active", boss_active, 1'b0);
    rst = 0;
    model_reset();

    foreach (vecs[k]) begin
      repeat (vecs[k].n) step(vecs[k].e, vecs[k].c, vecs[k].p);
      chk($sformatf("vec%0d_change", k), change, vecs[k].ch);
      chk($sformatf("vec%0d_mute", k), mute, vecs[k].mu);
      chk($sformatf("vec%0d_music_rst", k), music_rst, vecs[k].mr);
      chk($sformatf("vec%0d_boss_active", k), boss_active, vecs[k].ba);
    end

    step(1, 0, 0);
    run_gap("gap_len_to_boss", FULL);
    chk("gap_exit_change", change, 1'b1);
    chk("gap_exit_mute", mute, 1'b0);

    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("async_change", change, 1'b0);
    chk("async_mute", mute, 1'b0);
    chk("async_music_rst", music_rst, 1'b0);
    chk("async_boss_active", boss_active, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    run_gap("gap_len_after_rst", FULL);
    chk("after_rst_change", change, 1'b1);
    chk_int("sb_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bgm_sequencer.md
# bgm_sequencer

Upstream controller for the background-music player. It turns game events into the track-select level (`change`: 0 field, 1 boss), a mute level, and a one-cycle track-restart pulse. Every track switch is preceded by a silent gap of a fixed number of beats, and the new track always starts from beat 0. Downstream wiring: `change` drives the player's `change` input, `rst | music_rst` drives the player's `rst`, and `mute` gates the tone output (pmod_1 forced low while `mute`=1).

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BEAT_HZ`, 32, beat rate; matches the player's beat (one beat = 0.03125 s).
- `GAP_BEATS`, 16, silent beats between tracks (0.5 s); legal range 1..255.

Ports:
- `clk` input 1: system clock; one clock only.
- `rst` input 1: asynchronous, active-high reset.
- `boss_enter` input 1: one-cycle pulse when the player enters a boss room.
- `boss_clear` input 1: one-cycle pulse when the boss is defeated or the player leaves.
- `pause` input 1: level; high freezes the sequencer and mutes audio.
- `change` output 1: track select (0 field, 1 boss), registered.
- `mute` output 1: 1 = silence, registered.
- `music_rst` output 1: one-cycle restart pulse to the player, registered.
- `boss_active` output 1: 1 in GAP_TO_BOSS or BOSS (status for the game logic), registered.

## Operation
- States: FIELD, GAP_TO_BOSS, BOSS, GAP_TO_FIELD. Reset state is FIELD.
- Reset values of all outputs: `change`=0, `mute`=0, `music_rst`=0, `boss_active`=0.
- FIELD, on `boss_enter`: go to GAP_TO_BOSS. Clear the beat divider and load the gap counter with GAP_BEATS.
- BOSS, on `boss_clear`: go to GAP_TO_FIELD, with the same clear and load.
- In either gap state, each beat tick decrements the gap counter. When the counter reaches 0, go to BOSS (from GAP_TO_BOSS) or FIELD (from GAP_TO_FIELD), and pulse `music_rst` for one cycle.
- `change` updates in the same cycle that `music_rst` pulses. It never toggles outside a gap exit.
- Aborting a gap:
  - `boss_clear` in GAP_TO_BOSS goes to GAP_TO_FIELD, with the counter reloaded and the divider cleared.
  - `boss_enter` in GAP_TO_FIELD goes to GAP_TO_BOSS, likewise.
- Ignored events: `boss_enter` in BOSS or GAP_TO_BOSS, and `boss_clear` in FIELD or GAP_TO_FIELD.
- Simultaneous `boss_enter` and `boss_clear`: `boss_clear` wins, in every state.
- `mute` = `pause` OR (state is a gap state), evaluated on the next state and registered.
- `pause` behaviour:
  - While high, the beat divider and gap counter hold their values.
  - Events are still accepted and transitions still occur.
  - No `music_rst` can fire while paused.
- Beat divider: DIV = CLK_HZ/BEAT_HZ, integer division, DIV ≥ 2 required. The counter width is clog2(DIV).
  - Tick pulse occurs when the count reaches DIV-1. The count then wraps to 0.
  - The divider free-runs in FIELD and BOSS; ticks are unused there.

## Timing
- An event sampled at edge N gives the new state and outputs after edge N (the outputs are valid in cycle N+1). `mute` rises in cycle N+1.
- Gap length, measured from the first cycle with `mute`=1 to the `music_rst` cycle, is exactly GAP_BEATS·DIV cycles, excluding paused cycles.
- `music_rst` lasts exactly 1 cycle.
- In the cycle `music_rst` is high, `mute` falls to 0 (unless paused) and `change` holds its new value.
- `pause` takes effect with 1-cycle latency: `mute` goes high the cycle after `pause` is sampled high.
- Asserting `rst` mid-gap immediately forces FIELD and the reset output values, with no `music_rst` pulse.

## Structure
- Package `bgm_pkg`:
  - State enum: FIELD, GAP_TO_BOSS, BOSS, GAP_TO_FIELD.
  - Function computing DIV and the counter width from CLK_HZ/BEAT_HZ.
- Sub-module `beat_divider`:
  - Inputs `clk`, `rst`, `clr` (synchronous, highest priority) and `en`.
  - Output `tick`.
  - Instantiated once, with `en` = !`pause`.
- The top level holds the FSM, an 8-bit gap counter and the output registers.

## Test plan
All scenarios use CLK_HZ=320, BEAT_HZ=32 (DIV=10) and GAP_BEATS=4, giving a 40-cycle gap.
- Reset release, then idle for 100 cycles → `change`=0, `mute`=0, `music_rst` never high.
- `boss_enter` at cycle 10 → `mute`=1 during cycles 11–50. In cycle 51: `music_rst`=1 for one cycle, `change`=1, `mute`=0. `boss_active`=1 from cycle 11.
- In BOSS, `boss_clear` → a 40-cycle gap follows, then `change`=0 with one `music_rst`. `boss_enter` pulses during BOSS cause no effect.
- `boss_enter`, then `boss_clear` 15 cycles later → no `music_rst` at the original deadline. The gap restarts and exits to FIELD 40 cycles after `boss_clear`, with `change` staying 0 throughout.
- `boss_enter`, then `pause` held high for 25 cycles starting 10 cycles into the gap → `music_rst` is delayed by exactly 25 cycles. `mute` stays 1 continuously. A simultaneous `boss_enter` and `boss_clear` in FIELD is ignored.
- `rst` asserted asynchronously mid-gap → all outputs read 0 before the next clock edge. After release, the state is FIELD.
